// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder: WIDTH-bit operands, WIDTH+1 result, valid/ready flow.
// Define BK_ADDER_SAT_EN to saturate the result to the WIDTH-bit range on overflow.
module bk_adder_pipe #(
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH:0]  RST_SUM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int LOG = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bk_adder_pipe: WIDTH must be a power of two between 4 and 64");
  end

`ifdef BK_ADDER_SAT_EN
  function automatic logic [WIDTH:0] saturate(input logic [WIDTH:0] exact,
                                              input logic ovf, input logic sm);
    logic [WIDTH:0] r;
    r = exact;
    if (ovf) begin
      if (!sm)              r = {1'b0, {WIDTH{1'b1}}};
      else if (exact[WIDTH]) r = {2'b11, {(WIDTH-1){1'b0}}};
      else                  r = {2'b00, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction
`endif

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---- S1: bitwise propagate/generate, carry_in folded into bit 0 ----
  logic [WIDTH-1:0] p_s1, g_s1;
  always_comb begin
    p_s1    = a ^ b;
    g_s1    = a & b;
    g_s1[0] = g_s1[0] | (p_s1[0] & carry_in);
  end

  logic [WIDTH-1:0] p_p0, g_p0;
  logic             a_msb_p0, b_msb_p0, sm_p0, cin_p0, vld_p0;

  always_ff @(posedge clk) begin
    if (rst)          vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      p_p0     <= p_s1;
      g_p0     <= g_s1;
      a_msb_p0 <= a[WIDTH-1];
      b_msb_p0 <= b[WIDTH-1];
      sm_p0    <= signed_mode;
      cin_p0   <= carry_in;
    end
  end

  // ---- S2: up-sweep black cells, in place; a node at level l reads a lower node untouched at that level ----
  logic [WIDTH-1:0] gu, pu;
  always_comb begin
    gu = g_p0;
    pu = p_p0;
    for (int l = 0; l < LOG; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i + 1) % (1 << (l + 1)) == 0) begin
          gu[i] = gu[i] | (pu[i] & gu[i - (1 << l)]);
          pu[i] = pu[i] & pu[i - (1 << l)];
        end
      end
    end
  end

  logic [WIDTH-1:0] gg_p1, gp_p1, p_p1;
  logic             a_msb_p1, b_msb_p1, sm_p1, cin_p1, vld_p1;

  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      gg_p1    <= gu;
      gp_p1    <= pu;
      p_p1     <= p_p0;
      a_msb_p1 <= a_msb_p0;
      b_msb_p1 <= b_msb_p0;
      sm_p1    <= sm_p0;
      cin_p1   <= cin_p0;
    end
  end

  // ---- S3: down-sweep grey cells give prefix carries, then sum/overflow ----
  logic [WIDTH-1:0] gc;
  always_comb begin
    gc = gg_p1;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (l + 1)) && (i + 1) % (1 << (l + 1)) == (1 << l))
          gc[i] = gc[i] | (gp_p1[i] & gc[i - (1 << l)]);
      end
    end
  end

  logic [WIDTH:0] carry, exact_s3, sum_s3;
  logic           ovf_s3;
  always_comb begin
    carry    = {gc, cin_p1};
    exact_s3 = {1'b0, p_p1 ^ carry[WIDTH-1:0]};
    if (sm_p1) begin
      exact_s3[WIDTH] = a_msb_p1 ^ b_msb_p1 ^ carry[WIDTH];
      ovf_s3          = carry[WIDTH] ^ carry[WIDTH-1];
    end else begin
      exact_s3[WIDTH] = carry[WIDTH];
      ovf_s3          = carry[WIDTH];
    end
`ifdef BK_ADDER_SAT_EN
    sum_s3 = saturate(exact_s3, ovf_s3, sm_p1);
`else
    sum_s3 = exact_s3;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= RST_SUM;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        sum      <= sum_s3;
        overflow <= ovf_s3;
      end
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed bench for bk_adder_pipe (WIDTH=16): corner vectors, streaming, backpressure, reset flush.
module tb_bk_adder_pipe;

  localparam logic [16:0] RSTV = 17'h00ABC;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, carry_in, signed_mode, out_valid, out_ready, overflow;
  logic [15:0] a, b;
  logic [16:0] sum;
  int          checks = 0;
  int          errors = 0;

  bk_adder_pipe #(.WIDTH(16), .RST_SUM(RSTV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] pick(input logic [16:0] exact, input logic [16:0] sat);
`ifdef BK_ADDER_SAT_EN
    return sat;
`else
    return exact;
`endif
  endfunction

  // Reference: {overflow, sum} from plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [17:0] ex;
    logic [16:0] s;
    logic        ov;
    ex = {{2{ms & ma[15]}}, ma} + {{2{ms & mb[15]}}, mb} + {17'b0, mc};
    ov = ms ? (ex[16] ^ ex[15]) : ex[16];
    s  = ex[16:0];
`ifdef BK_ADDER_SAT_EN
    if (ov) s = !ms ? 17'h0FFFF : (ex[16] ? 17'h18000 : 17'h07FFF);
`endif
    return {ov, s};
  endfunction

  task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts, input logic [16:0] es, input logic eo);
    a = ta; b = tb; carry_in = tc; signed_mode = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; signed_mode = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_lat2"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_ovf"}, overflow, eo);
    tick();
  endtask

  // rmode: 0 = out_ready always 1, 1 = 5-cycle stall window, 2 = random out_ready
  task automatic stream(input string tag, input int n, input int rmode, input bit rnd_valid,
                        input bit rnd_sm, input bit chk_timing);
    logic [17:0] q[$];
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    bit accept, consume;
    while ((sent < n || got < n) && cyc < n * 6 + 40) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 6 && cyc < 11);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      a = 16'($urandom); b = 16'($urandom);
      carry_in = 1'($urandom_range(0, 1));
      signed_mode = rnd_sm ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = (sent < n) && (!rnd_valid || $urandom_range(0, 3) != 0);
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk({tag, "_spurious"}, out_valid, 0);
        else begin
          chk({tag, "_sum"}, sum, q[0][16:0]);
          chk({tag, "_ovf"}, overflow, q[0][17]);
        end
        if (!out_ready) chk({tag, "_stall_rdy"}, in_ready, 0);
      end
      accept  = in_valid && in_ready;
      consume = out_valid && out_ready;
      tick();
      if (consume && q.size() != 0) begin
        void'(q.pop_front());
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (accept) begin
        q.push_back(model(a, b, carry_in, signed_mode));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, got, n);
    chk({tag, "_left"}, q.size(), 0);
    if (chk_timing) begin
      chk({tag, "_first"}, first, 3);
      chk({tag, "_last"}, last, 3 + n - 1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; carry_in = 1'b0; signed_mode = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, RSTV);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    single("u_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, pick(17'h10000, 17'h0FFFF), 1'b1);
    single("s_pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b1, pick(17'h08000, 17'h07FFF), 1'b1);
    single("s_neg_ovf",  16'h8000, 16'hFFFF, 1'b0, 1'b1, pick(17'h17FFF, 17'h18000), 1'b1);
    single("u_cin_rip",  16'h00FF, 16'h0F00, 1'b1, 1'b0, 17'h01000, 1'b0);
    single("s_m1_m1_c",  16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF, 1'b0);
    single("u_plain",    16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0);
    single("s_min_min",  16'h8000, 16'h8000, 1'b0, 1'b1, pick(17'h10000, 17'h18000), 1'b1);
    single("u_zero_c",   16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 1'b0);
    single("s_max_max_c",16'h7FFF, 16'h7FFF, 1'b1, 1'b1, pick(17'h0FFFF, 17'h07FFF), 1'b1);
    single("u_all_c",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, pick(17'h1FFFF, 17'h0FFFF), 1'b1);

    stream("b2b", 8, 0, 1'b0, 1'b0, 1'b1);
    stream("bp", 12, 1, 1'b0, 1'b1, 1'b0);
    stream("rnd", 1000, 2, 1'b1, 1'b1, 1'b0);

    // Three results in flight, then reset flushes them all.
    out_ready = 1'b1; signed_mode = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
    a = 16'hFFFF; b = 16'h0001; tick();
    a = 16'h0002; b = 16'h0003; tick();
    a = 16'h0004; b = 16'h0005; tick();
    in_valid = 1'b0;
    chk("flush_pre_valid", out_valid, 1);
    chk("flush_pre_ovf", overflow, 1);
    rst = 1'b1;
    tick();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sum", sum, RSTV);
    chk("flush_ovf", overflow, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_output", out_valid, 0);
    end
    single("post_flush", 16'h0102, 16'h0304, 1'b1, 1'b0, 17'h00407, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_adder_pipe.md
Name: bk_adder_pipe

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder.
- Generalises the fixed 10-bit combinational adder to any power-of-two width.
- Adds a 3-stage registered pipeline with valid/ready handshake, a signed/unsigned mode and an overflow flag.
- Used as the final carry-propagate adder after the signed Dadda reduction tree, and as a standalone accumulate/add unit.

Parameters:
- WIDTH, 16, operand width; power of two, 4..64; non-compliant values are a compile-time error.
- RST_SUM, 0, value driven on sum after reset. Data registers are reset only when RST_SUM is used.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH+1  result.
- overflow  output  1  signed overflow (signed_mode=1) or carry-out (signed_mode=0).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: rst=1 at a clock edge clears all stage valid bits, out_valid=0, sum=RST_SUM, overflow=0. in_ready=1 in the cycle after reset is released.
- Reset mid-operation: all in-flight results are discarded, with no partial output.
- Pipeline stages (latency exactly 3 cycles from acceptance to out_valid, with no stalls):
  - S1: bitwise p=a^b, g=a&b. Bit 0 generate folds in carry_in: g0 = g0 | (p0 & carry_in). Register p, g, a[MSB], b[MSB], signed_mode, valid.
  - S2: Brent-Kung up-sweep, log2(WIDTH) levels of black cells: G=Gh|(Ph&Gl), P=Ph&Pl. Register group G/P, p, flags.
  - S3: down-sweep grey cells producing carries c[1..WIDTH]; sum bit i = p[i]^c[i], with c[0]=carry_in. Register sum and overflow.
- Handshake:
  - Global advance = !out_valid | out_ready; in_ready = advance.
  - A transfer occurs when in_valid & in_ready.
  - When advance=0, all stages hold: data and valid bits are frozen, and sum/overflow stay stable while out_valid=1.
  - Bubbles are not compacted.
  - in_valid=0 with advance=1 inserts a bubble.
- Throughput: one result per cycle while out_ready=1.
- Arithmetic:
  - Unsigned: sum = {c[WIDTH], sum[WIDTH-1:0]}; overflow = c[WIDTH].
  - Signed: sum[WIDTH] = a[MSB]^b[MSB]^c[WIDTH] (exact sign-extended result); overflow = c[WIDTH]^c[WIDTH-1].
  - The WIDTH+1 result is always exact unless saturation is enabled.
- Simultaneous events: rst has priority over transfers. A result leaving and an operand entering in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: BK_ADDER_SAT_EN.
- When defined, S3 saturates to the WIDTH-bit range when overflow=1:
  - Signed positive overflow: sum = sign-extended max (for WIDTH=16: 17'h07FFF).
  - Signed negative overflow: sum = sign-extended min (17'h18000).
  - Unsigned carry-out: sum = {1'b0, all ones} (17'h0FFFF).
  - The overflow flag is still asserted.
- When undefined: no saturation logic; sum is the exact WIDTH+1 result.
- Latency is unchanged in both builds.

Test Plan (WIDTH=16):
- Unsigned 0xFFFF+0x0001, cin=0 -> 3 cycles later sum=17'h10000, overflow=1; with SAT_EN sum=17'h0FFFF.
- Signed 0x7FFF+0x0001 -> sum=17'h08000, overflow=1; with SAT_EN sum=17'h07FFF. Signed 0x8000+0xFFFF -> sum=17'h17FFF, overflow=1; with SAT_EN 17'h18000.
- Carry-in ripple through full prefix: 0x00FF+0x0F00, cin=1 -> sum=17'h01000, overflow=0. Then 1000 random operands, both modes, any cin, checked against a behavioural model.
- Back-to-back: 8 operands on consecutive cycles with out_ready=1 -> 8 results on 8 consecutive cycles, in order, first result 3 cycles after the first acceptance.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1; sum held stable; no loss or duplication after release.
- Reset with 3 results in flight -> next cycle out_valid=0, sum=RST_SUM; a subsequent operand emerges exactly 3 cycles after its acceptance.
